// File: rtl/vga_timing_generator_pkg.sv
// Shared definitions for the VGA timing generator: FSM state encoding and
// standard mode timing sets.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } vga_state_t;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          h_pol;
    bit          v_pol;
  } vga_mode_t;

  localparam vga_mode_t SVGA_800x600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol: 1'b1, v_pol: 1'b1
  };

  localparam vga_mode_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0
  };

endpackage

// File: rtl/vga_timing_generator_if.sv
// Control and timing-output bundle of the VGA timing generator; the
// controller side is the master, the generator the slave.
interface vga_timing_if #(
  parameter int unsigned HW = 11,
  parameter int unsigned VW = 10,
  parameter int unsigned FW = 8
);
  logic          PIX_EN;
  logic          RUN;
  logic [HW-1:0] HCOUNT;
  logic [VW-1:0] VCOUNT;
  logic          HSYNC;
  logic          VSYNC;
  logic          ACTIVE_LOW_HBLANK;
  logic          ACTIVE_LOW_VBLANK;
  logic          DE;
  logic          LINE_START;
  logic          FRAME_START;
  logic [FW-1:0] FRAME_COUNT;

  modport master (
    output PIX_EN, RUN,
    input  HCOUNT, VCOUNT, HSYNC, VSYNC, ACTIVE_LOW_HBLANK, ACTIVE_LOW_VBLANK,
           DE, LINE_START, FRAME_START, FRAME_COUNT
  );

  modport slave (
    input  PIX_EN, RUN,
    output HCOUNT, VCOUNT, HSYNC, VSYNC, ACTIVE_LOW_HBLANK, ACTIVE_LOW_VBLANK,
           DE, LINE_START, FRAME_START, FRAME_COUNT
  );
endinterface

// File: rtl/vga_timing_generator_axis_decode.sv
// Per-axis region decoder: maps a pixel or line count to its in-active flag
// and its sync level; also rejects impossible region sets at elaboration.
module vga_axis_decode #(
  parameter int unsigned W      = 11,
  parameter int unsigned ACTIVE = 800,
  parameter int unsigned FP     = 40,
  parameter int unsigned SYNC   = 128,
  parameter int unsigned BP     = 88,
  parameter bit          POL    = 1'b1
) (
  input  logic [W-1:0] count,
  output logic         in_active,
  output logic         sync
);

  localparam longint unsigned TOTAL = 64'(ACTIVE) + 64'(FP) + 64'(SYNC) + 64'(BP);
  localparam longint unsigned SPAN  = 64'd1 << W;

  generate
    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || TOTAL > SPAN) begin : g_cfg_err
      $error("vga_axis_decode: region widths must be >= 1 and total must fit the counter");
    end
  endgenerate

  localparam logic [W-1:0] ACT_LAST   = W'(ACTIVE - 1);
  localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

  always_comb begin
    in_active = (count <= ACT_LAST);
    sync      = ((count >= SYNC_FIRST) && (count <= SYNC_LAST)) ? POL : ~POL;
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing generator: pixel/line counters with IDLE/ACTIVE/DRAIN control,
// registered sync, blank, DE, line/frame pulses and a completed-frame count.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = SVGA_800x600_60.h_active,
  parameter int unsigned H_FP       = SVGA_800x600_60.h_fp,
  parameter int unsigned H_SYNC     = SVGA_800x600_60.h_sync,
  parameter int unsigned H_BP       = SVGA_800x600_60.h_bp,
  parameter int unsigned V_ACTIVE   = SVGA_800x600_60.v_active,
  parameter int unsigned V_FP       = SVGA_800x600_60.v_fp,
  parameter int unsigned V_SYNC     = SVGA_800x600_60.v_sync,
  parameter int unsigned V_BP       = SVGA_800x600_60.v_bp,
  parameter bit          H_SYNC_POL = SVGA_800x600_60.h_pol,
  parameter bit          V_SYNC_POL = SVGA_800x600_60.v_pol,
  parameter int unsigned HW         = 11,
  parameter int unsigned VW         = 10,
  parameter int unsigned FW         = 8
) (
  input  logic        CLK_IN,
  input  logic        ACTIVE_LOW_RESET,
  vga_timing_if.slave bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  vga_state_t    state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          ls_d, fs_d;
  logic          h_last, v_last, end_frame, gen_on;
  logic          h_act_d, v_act_d, h_sync_d, v_sync_d;
  logic          de_q, hb_q, vb_q, hs_q, vs_q, ls_q, fs_q;

  // Decoders look at the next position so every flag lands with its counter.
  vga_axis_decode #(
    .W(HW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h_decode (
    .count     (h_d),
    .in_active (h_act_d),
    .sync      (h_sync_d)
  );

  vga_axis_decode #(
    .W(VW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v_decode (
    .count     (v_d),
    .in_active (v_act_d),
    .sync      (v_sync_d)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    fc_d      = fc_q;
    ls_d      = 1'b0;
    fs_d      = 1'b0;
    h_last    = (h_q == H_LAST);
    v_last    = (v_q == V_LAST);
    end_frame = h_last && v_last;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (bus.RUN) begin
          state_d = ST_ACTIVE;
          ls_d    = 1'b1;
          fs_d    = 1'b1;
        end
      end
      ST_ACTIVE, ST_DRAIN: begin
        if (h_last) begin
          h_d  = '0;
          ls_d = 1'b1;
          v_d  = v_last ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        if (end_frame) fc_d = fc_q + 1'b1;
        // RUN re-raised while draining resumes ACTIVE at the current position.
        if (bus.RUN) begin
          state_d = ST_ACTIVE;
          fs_d    = end_frame;
        end else if (state_q == ST_ACTIVE) begin
          state_d = ST_DRAIN;
          fs_d    = end_frame;
        end else if (end_frame) begin
          state_d = ST_IDLE;
          ls_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
    gen_on = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_IN or negedge ACTIVE_LOW_RESET) begin
    if (!ACTIVE_LOW_RESET) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      de_q    <= 1'b0;
      hb_q    <= 1'b0;
      vb_q    <= 1'b0;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (bus.PIX_EN) begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      de_q    <= gen_on && h_act_d && v_act_d;
      hb_q    <= gen_on && h_act_d;
      vb_q    <= gen_on && v_act_d;
      hs_q    <= gen_on ? h_sync_d : ~H_SYNC_POL;
      vs_q    <= gen_on ? v_sync_d : ~V_SYNC_POL;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end
  end

  assign bus.HCOUNT            = h_q;
  assign bus.VCOUNT            = v_q;
  assign bus.FRAME_COUNT       = fc_q;
  assign bus.DE                = de_q;
  assign bus.ACTIVE_LOW_HBLANK = hb_q;
  assign bus.ACTIVE_LOW_VBLANK = vb_q;
  assign bus.HSYNC             = hs_q;
  assign bus.VSYNC             = vs_q;
  assign bus.LINE_START        = ls_q;
  assign bus.FRAME_START       = fs_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator in a tiny 8x6 mode; two instances
// (positive sync/FW=8 and negative sync/FW=2) share the same stimulus.
module tb_vga_timing_generator;

  typedef struct {
    int h, v, de, hb, vb, hs_on, vs_on, ls, fs, frames;
  } exp_t;

  logic clk, rst_n, pix_en, run;
  bit   clk_on;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Reference model: linear pixel index within an 8x6 frame.
  bit m_idle, m_drain;
  int m_p, m_frames, m_ls, m_fs;

  // Pulse spacing observed on instance a.
  int cyc = 0, ls_prev = 0, fs_prev = 0, ls_per = 0, fs_per = 0;
  bit ls_have = 0, fs_have = 0;

  vga_timing_if #(.HW(3), .VW(3), .FW(8)) bus_a ();
  vga_timing_if #(.HW(3), .VW(3), .FW(2)) bus_b ();

  assign bus_a.PIX_EN = pix_en;
  assign bus_a.RUN    = run;
  assign bus_b.PIX_EN = pix_en;
  assign bus_b.RUN    = run;

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .HW(3), .VW(3), .FW(8)
  ) dut_a (
    .CLK_IN           (clk),
    .ACTIVE_LOW_RESET (rst_n),
    .bus              (bus_a)
  );

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .HW(3), .VW(3), .FW(2)
  ) dut_b (
    .CLK_IN           (clk),
    .ACTIVE_LOW_RESET (rst_n),
    .bus              (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_on) clk = ~clk;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input bit hpol, input bit vpol,
                           input int fmask, input int h, v, de, hb, vb, hs, vs, ls, fs, fc);
    chk({tag, "_hcount"}, h, e.h);
    chk({tag, "_vcount"}, v, e.v);
    chk({tag, "_de"}, de, e.de);
    chk({tag, "_hblank_n"}, hb, e.hb);
    chk({tag, "_vblank_n"}, vb, e.vb);
    chk({tag, "_hsync"}, hs, e.hs_on != 0 ? int'(hpol) : int'(!hpol));
    chk({tag, "_vsync"}, vs, e.vs_on != 0 ? int'(vpol) : int'(!vpol));
    chk({tag, "_line_start"}, ls, e.ls);
    chk({tag, "_frame_start"}, fs, e.fs);
    chk({tag, "_frame_count"}, fc, e.frames & fmask);
  endtask

  task automatic check_both(input string tag, input exp_t e);
    check_dut({tag, "_a"}, e, 1'b1, 1'b1, 255,
              bus_a.HCOUNT, bus_a.VCOUNT, bus_a.DE, bus_a.ACTIVE_LOW_HBLANK,
              bus_a.ACTIVE_LOW_VBLANK, bus_a.HSYNC, bus_a.VSYNC, bus_a.LINE_START,
              bus_a.FRAME_START, bus_a.FRAME_COUNT);
    check_dut({tag, "_b"}, e, 1'b0, 1'b0, 3,
              bus_b.HCOUNT, bus_b.VCOUNT, bus_b.DE, bus_b.ACTIVE_LOW_HBLANK,
              bus_b.ACTIVE_LOW_VBLANK, bus_b.HSYNC, bus_b.VSYNC, bus_b.LINE_START,
              bus_b.FRAME_START, bus_b.FRAME_COUNT);
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    bit   on;
    on       = !m_idle;
    e.h      = on ? m_p % 8 : 0;
    e.v      = on ? m_p / 8 : 0;
    e.de     = int'(on && e.h < 4 && e.v < 3);
    e.hb     = int'(on && e.h < 4);
    e.vb     = int'(on && e.v < 3);
    e.hs_on  = int'(on && e.h >= 5 && e.h <= 6);
    e.vs_on  = int'(on && e.v == 4);
    e.ls     = m_ls;
    e.fs     = m_fs;
    e.frames = m_frames;
    return e;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_drain = 0; m_p = 0; m_frames = 0; m_ls = 0; m_fs = 0;
    ls_have = 0; fs_have = 0;
  endtask

  task automatic model_step(input bit pe, input bit rn);
    bit last;
    if (!pe) begin
      m_ls = 0;
      m_fs = 0;
    end else if (m_idle) begin
      m_ls = int'(rn);
      m_fs = int'(rn);
      if (rn) begin
        m_idle  = 0;
        m_drain = 0;
        m_p     = 0;
      end
    end else begin
      last = (m_p == 47);
      m_p  = (m_p + 1) % 48;
      m_ls = int'(m_p % 8 == 0);
      m_fs = int'(last && (!m_drain || rn));
      if (last) m_frames++;
      if (m_drain && !rn && last) begin
        m_idle = 1;
        m_p    = 0;
        m_ls   = 0;
      end
      m_drain = !rn;
    end
  endtask

  task automatic step(input bit pe, input bit rn);
    pix_en = pe;
    run    = rn;
    @(posedge clk);
    model_step(pe, rn);
    sb.push_back(model_outputs());
    #1;
  endtask

  task automatic arm(input int fs_p, input int ls_p);
    fs_per  = fs_p;
    ls_per  = ls_p;
    fs_have = 0;
    ls_have = 0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      check_both("cyc", e);
    end
    if (rst_n && bus_a.LINE_START) begin
      if (ls_have && ls_per != 0) chk("line_start_period", cyc - ls_prev, ls_per);
      ls_prev = cyc;
      ls_have = 1;
    end
    if (rst_n && bus_a.FRAME_START) begin
      if (fs_have && fs_per != 0) chk("frame_start_period", cyc - fs_prev, fs_per);
      fs_prev = cyc;
      fs_have = 1;
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t rst_e;
    bit   rn;
    rst_e  = '{default: 0};
    rst_n  = 1'b0;
    pix_en = 1'b0;
    run    = 1'b0;
    clk_on = 1'b1;
    model_reset();
    #12;
    check_both("por", rst_e);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);

    // Run to (3,2), stop the clock, then reset asynchronously.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    @(negedge clk);
    clk_on = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_both("async_rst", rst_e);
    sb.delete();
    model_reset();
    #3 rst_n = 1'b1;
    clk_on = 1'b1;

    for (int i = 0; i < 251; i++) begin
      if (i == 3) arm(48, 8);
      step(1'b1, 1'b1);
    end
    arm(0, 0);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0);

    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1);

    for (int i = 0; i < 450; i++) begin
      if (i == 6) arm(144, 24);
      step(i % 3 == 0, 1'b1);
    end
    arm(0, 0);

    rn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rn = !rn;
      step($urandom_range(0, 3) != 0, rn);
    end

    pix_en = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
